// File: rtl/adc_fir_pkg.sv
// rtl/adc_fir_pkg.sv - shared states and frame constants for the ADC/FIR sample sequencer
package adc_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_FILT,
        ST_OUT
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADC_BITS   = FRAME_BITS - LEAD_ZEROS;

    // sclk edges are counted (two per bit), so the counter must reach 2*FRAME_BITS
    localparam int EDGE_W     = $clog2(2 * FRAME_BITS + 1);

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample-period wrap counter producing the sampling tick
module sample_tick_gen #(
    parameter int SAMPLE_PERIOD = 2500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] count;

    // free-running period counter; held at zero while sampling is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/adc_fir_sequencer.sv
// rtl/adc_fir_sequencer.sv - ADC frame capture, FIR start and DAC launch sequencer
module adc_fir_sequencer
    import adc_fir_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 2500,
    parameter int SCLK_HALF     = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                adc_sdata,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [ADC_BITS-1:0] sample,
    output logic                sample_valid,
    output logic                filt_start,
    input  logic                filt_done,
    output logic                dac_start,
    input  logic                dac_busy,
    output logic                overrun,
    output logic                err_timeout
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [HW-1:0]       half_cnt, half_nxt;
    logic [EDGE_W-1:0]   edge_cnt, edge_nxt;
    logic [TW-1:0]       tcnt, tcnt_nxt;
    logic [ADC_BITS-1:0] shreg, shreg_nxt;
    logic [ADC_BITS-1:0] sample_nxt;
    logic                cs_nxt, sclk_nxt, valid_nxt, fstart_nxt, dstart_nxt;
    logic                overrun_nxt, err_nxt;
    logic                tick;

    sample_tick_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .tick   (tick)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state plus next values of every registered output and counter
    always_comb begin
        state_nxt   = state;
        half_nxt    = half_cnt;
        edge_nxt    = edge_cnt;
        tcnt_nxt    = tcnt;
        shreg_nxt   = shreg;
        sample_nxt  = sample;
        cs_nxt      = 1'b1;
        sclk_nxt    = 1'b1;
        valid_nxt   = 1'b0;
        fstart_nxt  = 1'b0;
        dstart_nxt  = 1'b0;
        overrun_nxt = overrun;
        err_nxt     = err_timeout;

        if (!enable) begin
            state_nxt   = ST_IDLE;
            overrun_nxt = 1'b0;
            err_nxt     = 1'b0;
        end else begin
            // a tick outside IDLE is dropped, only flagged
            if (tick && (state != ST_IDLE)) begin
                overrun_nxt = 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state_nxt = ST_CONV;
                        cs_nxt    = 1'b0;
                        half_nxt  = '0;
                        edge_nxt  = '0;
                    end
                end
                ST_CONV: begin
                    if (edge_cnt == EDGE_W'(2 * FRAME_BITS)) begin
                        // last rising edge already seen: close the frame
                        state_nxt  = ST_FILT;
                        sample_nxt = shreg;
                        valid_nxt  = 1'b1;
                        fstart_nxt = 1'b1;
                        tcnt_nxt   = '0;
                    end else begin
                        cs_nxt   = 1'b0;
                        sclk_nxt = adc_sclk;
                        if (half_cnt == HW'(SCLK_HALF - 1)) begin
                            half_nxt = '0;
                            sclk_nxt = !adc_sclk;
                            edge_nxt = edge_cnt + 1'b1;
                            // capture on the low-to-high sclk transition; the
                            // leading zero bits fall off the top of the register
                            if (!adc_sclk) begin
                                shreg_nxt = {shreg[ADC_BITS-2:0], adc_sdata};
                            end
                        end else begin
                            half_nxt = half_cnt + 1'b1;
                        end
                    end
                end
                ST_FILT: begin
                    if (filt_done) begin
                        state_nxt = ST_OUT;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (!dac_busy) begin
                        state_nxt  = ST_IDLE;
                        dstart_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // registered outputs, serial counters and shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt     <= '0;
            edge_cnt     <= '0;
            tcnt         <= '0;
            shreg        <= '0;
            sample       <= '0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            sample_valid <= 1'b0;
            filt_start   <= 1'b0;
            dac_start    <= 1'b0;
            overrun      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            half_cnt     <= half_nxt;
            edge_cnt     <= edge_nxt;
            tcnt         <= tcnt_nxt;
            shreg        <= shreg_nxt;
            sample       <= sample_nxt;
            adc_cs_n     <= cs_nxt;
            adc_sclk     <= sclk_nxt;
            sample_valid <= valid_nxt;
            filt_start   <= fstart_nxt;
            dac_start    <= dstart_nxt;
            overrun      <= overrun_nxt;
            err_timeout  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_adc_fir_sequencer.sv
// tb/tb_adc_fir_sequencer.sv - self-checking bench for adc_fir_sequencer
module tb_adc_fir_sequencer;

    localparam int SP  = 200;
    localparam int H   = 2;
    localparam int TO  = 255;
    localparam int LAT = 2 + 32 * H;

    logic        clk = 1'b0;
    logic        reset_n, enable, adc_sdata, adc_cs_n, adc_sclk;
    logic        sample_valid, filt_start, filt_done, dac_start, dac_busy;
    logic        overrun, err_timeout;
    logic [11:0] sample;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          next_tick = 0;
    int          bitidx = 0;
    logic        sclk_prev = 1'b1;
    logic [15:0] frame = 16'h0000;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    typedef struct {
        logic [15:0] fr;
        int          dly;
        int          busy;
        logic [11:0] ex;
    } vec_t;
    vec_t vecs[5];

    adc_fir_sequencer #(
        .SAMPLE_PERIOD(SP),
        .SCLK_HALF    (H),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .adc_sdata   (adc_sdata),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .sample      (sample),
        .sample_valid(sample_valid),
        .filt_start  (filt_start),
        .filt_done   (filt_done),
        .dac_start   (dac_start),
        .dac_busy    (dac_busy),
        .overrun     (overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: presents the next frame bit, MSB first, ahead of each sclk rise
    assign adc_sdata = (bitidx < 16) ? frame[15 - bitidx] : 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard and sclk edge counter, sampled on the falling clk edge
    always @(negedge clk) begin
        if (reset_n && sample_valid) begin
            check("sclk_rises", bitidx, 16);
            check("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sample", sample, mon_e);
            end
        end
        if (adc_cs_n) bitidx = 0;
        else if (adc_sclk && !sclk_prev) bitidx++;
        sclk_prev = adc_sclk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return sample_valid;
            1:       return dac_start;
            2:       return err_timeout;
            3:       return overrun;
            default: return !adc_cs_n;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sel(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic run_frame(input logic [15:0] fr, input logic [11:0] ex, input int dly,
                             input int busy, input bit chk_ovr, input string tag);
        int at, d;
        frame = fr;
        exp_q.push_back(ex);
        wait_for(0, 2 * SP + LAT + 10, {tag, "_valid"}, at);
        check({tag, "_valid_cyc"}, at, next_tick + LAT);
        check({tag, "_filt_start"}, filt_start, 1);
        repeat (dly) step();
        filt_done = 1'b1;
        d = cyc;
        if (busy > 0) dac_busy = 1'b1;
        step();
        filt_done = 1'b0;
        if (busy > 0) begin
            repeat (busy) step();
            dac_busy = 1'b0;
        end
        wait_for(1, 40, {tag, "_dac"}, at);
        check({tag, "_dac_cyc"}, at, d + busy + 2);
        step();
        check({tag, "_dac_single"}, dac_start, 0);
        if (chk_ovr) check({tag, "_no_overrun"}, overrun, 0);
        next_tick += SP;
    endtask

    task automatic enable_pulse(input string tag);
        enable = 1'b0;
        step();
        check({tag, "_ovr_clr"}, overrun, 0);
        check({tag, "_err_clr"}, err_timeout, 0);
        enable = 1'b1;
        next_tick = cyc + SP - 1;
    endtask

    initial begin
        int at, f, d, bad;

        vecs[0] = '{16'h0A5C, 10, 0, 12'hA5C};
        vecs[1] = '{16'hFFFF, 3, 20, 12'hFFF};
        vecs[2] = '{16'h5123, 1, 0, 12'h123};
        vecs[3] = '{16'h0000, 0, 0, 12'h000};
        vecs[4] = '{16'h0801, 100, 5, 12'h801};

        reset_n = 1'b0; enable = 1'b0; filt_done = 1'b0; dac_busy = 1'b0;
        repeat (3) step();
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_fstart", filt_start, 0);
        check("rst_dstart", dac_start, 0);
        check("rst_overrun", overrun, 0);
        check("rst_err", err_timeout, 0);

        // reset asserted in the middle of a conversion
        reset_n = 1'b1; enable = 1'b1;
        next_tick = cyc + SP - 1;
        wait_for(4, SP + 10, "first_conv", at);
        check("first_conv_cyc", at, next_tick + 1);
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        check("midrst_cs_n", adc_cs_n, 1);
        check("midrst_sclk", adc_sclk, 1);
        check("midrst_sample", sample, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_err", err_timeout, 0);
        step();
        reset_n = 1'b1;
        next_tick = cyc + SP - 1;

        // normal frames, busy-delayed DAC and zero-delay filt_done
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].fr, vecs[i].ex, vecs[i].dly, vecs[i].busy, 1'b1, $sformatf("vec%0d", i));
        end

        // filter timeout: intervening tick is an overrun, next one runs a frame
        frame = 16'h0ABC;
        exp_q.push_back(12'hABC);
        wait_for(0, 2 * SP + LAT, "to_valid", at);
        check("to_valid_cyc", at, next_tick + LAT);
        f = at;
        wait_for(2, TO + 20, "to_err", at);
        check("to_err_cyc", at, f + TO);
        check("to_idle_cs", adc_cs_n, 1);
        check("to_overrun", overrun, 1);
        filt_done = 1'b1;
        step();
        filt_done = 1'b0;
        bad = 0;
        repeat (6) begin
            step();
            if (dac_start) bad++;
        end
        check("stray_done_ignored", bad, 0);
        next_tick += 2 * SP;
        run_frame(16'h0123, 12'h123, 5, 0, 1'b0, "after_to");
        enable_pulse("en1");

        // DAC busy past the next tick
        frame = 16'h0F0F;
        exp_q.push_back(12'hF0F);
        wait_for(0, 2 * SP + LAT, "ovr_valid", at);
        check("ovr_valid_cyc", at, next_tick + LAT);
        step();
        step();
        filt_done = 1'b1;
        d = cyc;
        dac_busy = 1'b1;
        step();
        filt_done = 1'b0;
        wait_for(3, SP, "ovr_flag", at);
        check("ovr_flag_cyc", at, next_tick + SP + 1);
        bad = 0;
        while (cyc < d + 301) begin
            step();
            if (!adc_cs_n || sample_valid) bad++;
        end
        check("ovr_no_frame", bad, 0);
        dac_busy = 1'b0;
        wait_for(1, 20, "ovr_dac", at);
        check("ovr_dac_cyc", at, d + 302);
        next_tick += 2 * SP;
        run_frame(16'h0333, 12'h333, 0, 0, 1'b0, "after_ovr");
        check("ovr_sticky", overrun, 1);
        enable_pulse("en2");

        // enable dropped at the 8th sclk rising edge
        frame = 16'h0FFF;
        at = -1;
        for (int i = 0; i < 2 * SP + LAT; i++) begin
            step();
            if (bitidx == 8) begin
                at = cyc;
                break;
            end
        end
        check("abort_reached_edge8", int'(at >= 0), 1);
        enable = 1'b0;
        step();
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 1);
        bad = 0;
        repeat (80) begin
            step();
            if (!adc_cs_n || !adc_sclk || sample_valid || filt_start) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_sample_hold", sample, 12'h333);
        enable = 1'b1;
        next_tick = cyc + SP - 1;
        run_frame(16'h0765, 12'h765, 4, 3, 1'b1, "reenable");

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
